// File: rtl/ctrl_pkg.sv
// Shared definitions for the multi-cycle RV32I-subset control FSM:
// opcode constants, FSM state encoding, ALUOp and trap cause encodings.
package ctrl_pkg;

    localparam logic [6:0] R_TYPE = 7'b0110011;
    localparam logic [6:0] I_TYPE = 7'b0010011;
    localparam logic [6:0] LW     = 7'b0000011;
    localparam logic [6:0] SW     = 7'b0100011;
    localparam logic [6:0] BR     = 7'b1100011;
    localparam logic [6:0] JAL    = 7'b1101111;
    localparam logic [6:0] JALR   = 7'b1100111;
    localparam logic [6:0] HALT   = 7'b1111111;

    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        DECODE = 3'd1,
        EXEC   = 3'd2,
        MEM    = 3'd3,
        WB     = 3'd4,
        HALTED = 3'd5,
        TRAP   = 3'd6
    } state_t;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;  // LW/SW/JALR address add
    localparam logic [1:0] ALUOP_BR    = 2'b01;  // branch compare
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;  // R/I-type, funct decoded

    localparam logic [1:0] CAUSE_NONE    = 2'b00;
    localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
    localparam logic [1:0] CAUSE_IMEM_TO = 2'b10;
    localparam logic [1:0] CAUSE_DMEM_TO = 2'b11;

    // Opcodes that take the normal EXEC path (HALT is handled separately).
    function automatic logic is_known_op(input logic [6:0] op);
        logic known;
        case (op)
            R_TYPE, I_TYPE, LW, SW, BR, JAL, JALR: known = 1'b1;
            default:                               known = 1'b0;
        endcase
        return known;
    endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Counts consecutive cycles a memory handshake is stalled. Flags a timeout
// in the cycle that would bring the count to MEM_TIMEOUT while still
// stalled; a ready in that cycle drops enable and so suppresses the flag.
module mem_wait_timer #(
    parameter int MEM_TIMEOUT = 15
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic timeout
);

    localparam int CW = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] LAST = (MEM_TIMEOUT > 0) ? CW'(MEM_TIMEOUT - 1) : '0;

    logic [CW-1:0] cnt_q;

    // Timeout fires on the stalled cycle whose increment would reach the limit.
    always_comb begin
        timeout = 1'b0;
        if (MEM_TIMEOUT > 0) begin
            timeout = enable && (cnt_q == LAST);
        end
    end

    // Wait counter: cleared on phase entry, advances on each stalled cycle.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            cnt_q <= '0;
        end else if (enable && !timeout) begin
            cnt_q <= cnt_q + CW'(1);
        end
    end

endmodule

// File: rtl/multicycle_controller.sv
// Multi-cycle control FSM for the RV32I subset. Issues datapath strobes one
// phase at a time, stretches FETCH/MEM until the memories answer, traps on
// illegal opcodes or memory timeouts, and counts retired instructions.
module multicycle_controller
    import ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 15,
    parameter int RET_W       = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [6:0]       Opcode,
    input  logic             imem_ready,
    input  logic             dmem_ready,
    output logic             IMemReq,
    output logic             IRWrite,
    output logic             PCWrite,
    output logic             Branch,
    output logic             ALUSrc,
    output logic             MemtoReg,
    output logic             RegWrite,
    output logic             MemRead,
    output logic             MemWrite,
    output logic             JalPrima,
    output logic             JalrSel,
    output logic             RWSel,
    output logic [1:0]       ALUOp,
    output logic             Halt,
    output logic             Trap,
    output logic [1:0]       trap_cause,
    output logic [RET_W-1:0] retired
);

    state_t           state_q, state_d;
    logic [6:0]       op_q;
    logic [1:0]       cause_q, cause_d;
    logic [RET_W-1:0] ret_q;

    logic       latch_op, retire;
    logic       wait_en, wait_clear, wait_timeout;

    logic       imem_req, ir_write, pc_write, branch, alu_src, mem_to_reg;
    logic       reg_write, mem_read, mem_write, jal_prima, jalr_sel, rw_sel;
    logic [1:0] alu_op;

    // A stall cycle is one spent in FETCH or MEM without the matching ready.
    assign wait_en    = ((state_q == FETCH) && !imem_ready) ||
                        ((state_q == MEM)   && !dmem_ready);
    // Any state change restarts the wait count, covering entry to FETCH and MEM.
    assign wait_clear = (state_d != state_q);

    mem_wait_timer #(
        .MEM_TIMEOUT(MEM_TIMEOUT)
    ) u_wait_timer (
        .clk    (clk),
        .reset  (reset),
        .clear  (wait_clear),
        .enable (wait_en),
        .timeout(wait_timeout)
    );

    // Next-state and per-phase strobe decode from state and latched opcode.
    always_comb begin
        state_d    = state_q;
        cause_d    = cause_q;
        latch_op   = 1'b0;
        retire     = 1'b0;
        imem_req   = 1'b0;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        branch     = 1'b0;
        alu_src    = 1'b0;
        mem_to_reg = 1'b0;
        reg_write  = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        jal_prima  = 1'b0;
        jalr_sel   = 1'b0;
        rw_sel     = 1'b0;
        alu_op     = ALUOP_ADD;

        case (state_q)
            FETCH: begin
                imem_req = 1'b1;
                if (imem_ready) begin
                    ir_write = 1'b1;
                    latch_op = 1'b1;
                    state_d  = DECODE;
                end else if (wait_timeout) begin
                    state_d = TRAP;
                    cause_d = CAUSE_IMEM_TO;
                end
            end

            DECODE: begin
                if (op_q == HALT) begin
                    state_d = HALTED;
                end else if (!is_known_op(op_q)) begin
                    state_d = TRAP;
                    cause_d = CAUSE_ILLEGAL;
                end else begin
                    state_d = EXEC;
                end
            end

            EXEC: begin
                case (op_q)
                    BR: begin
                        alu_op   = ALUOP_BR;
                        branch   = 1'b1;
                        pc_write = 1'b1;
                        retire   = 1'b1;
                        state_d  = FETCH;
                    end
                    JAL: begin
                        jal_prima = 1'b1;
                        rw_sel    = 1'b1;
                        reg_write = 1'b1;
                        pc_write  = 1'b1;
                        retire    = 1'b1;
                        state_d   = FETCH;
                    end
                    JALR: begin
                        jalr_sel  = 1'b1;
                        rw_sel    = 1'b1;
                        reg_write = 1'b1;
                        alu_src   = 1'b1;
                        pc_write  = 1'b1;
                        retire    = 1'b1;
                        state_d   = FETCH;
                    end
                    LW, SW: begin
                        alu_src = 1'b1;
                        state_d = MEM;
                    end
                    R_TYPE: begin
                        alu_op  = ALUOP_FUNCT;
                        state_d = WB;
                    end
                    I_TYPE: begin
                        alu_op  = ALUOP_FUNCT;
                        alu_src = 1'b1;
                        state_d = WB;
                    end
                    default: begin
                        // Unreachable: DECODE filters unknown opcodes.
                        state_d = TRAP;
                        cause_d = CAUSE_ILLEGAL;
                    end
                endcase
            end

            MEM: begin
                if (op_q == LW) begin
                    mem_read = 1'b1;
                end else begin
                    mem_write = 1'b1;
                end
                if (dmem_ready) begin
                    if (op_q == LW) begin
                        state_d = WB;
                    end else begin
                        pc_write = 1'b1;
                        retire   = 1'b1;
                        state_d  = FETCH;
                    end
                end else if (wait_timeout) begin
                    state_d = TRAP;
                    cause_d = CAUSE_DMEM_TO;
                end
            end

            WB: begin
                reg_write  = 1'b1;
                pc_write   = 1'b1;
                mem_to_reg = (op_q == LW);
                retire     = 1'b1;
                state_d    = FETCH;
            end

            HALTED, TRAP: begin
                state_d = state_q;
            end

            default: begin
                state_d = FETCH;
            end
        endcase
    end

    // FSM state and sticky trap cause.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= FETCH;
            cause_q <= CAUSE_NONE;
        end else begin
            state_q <= state_d;
            cause_q <= cause_d;
        end
    end

    // Opcode register, loaded only on the FETCH handshake.
    always_ff @(posedge clk) begin
        if (reset) begin
            op_q <= '0;
        end else if (latch_op) begin
            op_q <= Opcode;
        end
    end

    // Retired-instruction counter, wraps naturally.
    always_ff @(posedge clk) begin
        if (reset) begin
            ret_q <= '0;
        end else if (retire) begin
            ret_q <= ret_q + RET_W'(1);
        end
    end

    // Reset forces every output low, including the cycle reset is first seen,
    // so an in-flight memory strobe is dropped immediately.
    assign IMemReq    = !reset && imem_req;
    assign IRWrite    = !reset && ir_write;
    assign PCWrite    = !reset && pc_write;
    assign Branch     = !reset && branch;
    assign ALUSrc     = !reset && alu_src;
    assign MemtoReg   = !reset && mem_to_reg;
    assign RegWrite   = !reset && reg_write;
    assign MemRead    = !reset && mem_read;
    assign MemWrite   = !reset && mem_write;
    assign JalPrima   = !reset && jal_prima;
    assign JalrSel    = !reset && jalr_sel;
    assign RWSel      = !reset && rw_sel;
    assign ALUOp      = reset ? 2'b00 : alu_op;
    assign Halt       = !reset && (state_q == HALTED);
    assign Trap       = !reset && (state_q == TRAP);
    assign trap_cause = reset ? CAUSE_NONE : cause_q;
    assign retired    = reset ? '0 : ret_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller: instruction sequences with
// hand-computed per-cycle strobe patterns, memory waits, timeouts, traps,
// halt and mid-instruction reset.
module tb_multicycle_controller;

    localparam logic [6:0] OP_ADD  = 7'b0110011;
    localparam logic [6:0] OP_ITY  = 7'b0010011;
    localparam logic [6:0] OP_LW   = 7'b0000011;
    localparam logic [6:0] OP_SW   = 7'b0100011;
    localparam logic [6:0] OP_BR   = 7'b1100011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;
    localparam logic [6:0] OP_JALR = 7'b1100111;
    localparam logic [6:0] OP_HALT = 7'b1111111;

    // Strobe bit positions in the packed observation vector.
    localparam logic [15:0] IMEM   = 16'h8000;
    localparam logic [15:0] IRW    = 16'h4000;
    localparam logic [15:0] PCW    = 16'h2000;
    localparam logic [15:0] BRN    = 16'h1000;
    localparam logic [15:0] ASRC   = 16'h0800;
    localparam logic [15:0] M2R    = 16'h0400;
    localparam logic [15:0] RGW    = 16'h0200;
    localparam logic [15:0] MRD    = 16'h0100;
    localparam logic [15:0] MWR    = 16'h0080;
    localparam logic [15:0] JALP   = 16'h0040;
    localparam logic [15:0] JRS    = 16'h0020;
    localparam logic [15:0] RWS    = 16'h0010;
    localparam logic [15:0] AOP_RI = 16'h0008;
    localparam logic [15:0] AOP_BR = 16'h0004;
    localparam logic [15:0] HLT    = 16'h0002;
    localparam logic [15:0] TRP    = 16'h0001;
    localparam logic [15:0] NONE   = 16'h0000;

    logic        clk = 1'b0;
    logic        reset;
    logic [6:0]  Opcode;
    logic        imem_ready, dmem_ready;
    logic        IMemReq, IRWrite, PCWrite, Branch, ALUSrc, MemtoReg, RegWrite;
    logic        MemRead, MemWrite, JalPrima, JalrSel, RWSel, Halt, Trap;
    logic [1:0]  ALUOp, trap_cause;
    logic [31:0] retired;
    logic [15:0] strb;

    int n_checks = 0;
    int n_fails  = 0;

    multicycle_controller #(
        .MEM_TIMEOUT(15),
        .RET_W      (32)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .Opcode    (Opcode),
        .imem_ready(imem_ready),
        .dmem_ready(dmem_ready),
        .IMemReq   (IMemReq),
        .IRWrite   (IRWrite),
        .PCWrite   (PCWrite),
        .Branch    (Branch),
        .ALUSrc    (ALUSrc),
        .MemtoReg  (MemtoReg),
        .RegWrite  (RegWrite),
        .MemRead   (MemRead),
        .MemWrite  (MemWrite),
        .JalPrima  (JalPrima),
        .JalrSel   (JalrSel),
        .RWSel     (RWSel),
        .ALUOp     (ALUOp),
        .Halt      (Halt),
        .Trap      (Trap),
        .trap_cause(trap_cause),
        .retired   (retired)
    );

    always #5 clk = ~clk;

    assign strb = {IMemReq, IRWrite, PCWrite, Branch, ALUSrc, MemtoReg, RegWrite,
                   MemRead, MemWrite, JalPrima, JalrSel, RWSel, ALUOp, Halt, Trap};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one clock, then apply this cycle's inputs and let outputs settle.
    task automatic cyc(input logic rst, input logic [6:0] op, input logic im, input logic dm);
        @(posedge clk);
        #1;
        reset      = rst;
        Opcode     = op;
        imem_ready = im;
        dmem_ready = dm;
        #1;
    endtask

    initial begin
        reset = 1'b1; Opcode = '0; imem_ready = 1'b0; dmem_ready = 1'b0;

        // Reset state
        cyc(1, 7'd0, 0, 0);
        cyc(1, 7'd0, 0, 0);
        chk("reset_strobes", 32'(strb), 32'(NONE));
        chk("reset_retired", retired, 32'd0);
        chk("reset_cause", 32'(trap_cause), 32'd0);

        // ADD, zero-wait: 4 cycles
        cyc(0, OP_ADD, 1, 1); chk("add_fetch", 32'(strb), 32'(IMEM | IRW));
        cyc(0, OP_ADD, 1, 1); chk("add_decode", 32'(strb), 32'(NONE));
        cyc(0, OP_ADD, 1, 1); chk("add_exec", 32'(strb), 32'(AOP_RI));
        cyc(0, OP_LW, 1, 1);  chk("add_wb", 32'(strb), 32'(RGW | PCW));
        chk("add_wb_retired", retired, 32'd0);

        // LW with three data-memory wait cycles: 8 cycles
        cyc(0, OP_LW, 1, 1);  chk("lw_fetch", 32'(strb), 32'(IMEM | IRW));
        chk("add_retired", retired, 32'd1);
        cyc(0, OP_LW, 1, 0);  chk("lw_decode", 32'(strb), 32'(NONE));
        cyc(0, OP_LW, 1, 0);  chk("lw_exec", 32'(strb), 32'(ASRC));
        for (int i = 0; i < 3; i++) begin
            cyc(0, OP_LW, 1, 0); chk("lw_mem_wait", 32'(strb), 32'(MRD));
        end
        cyc(0, OP_LW, 1, 1);  chk("lw_mem_ready", 32'(strb), 32'(MRD));
        cyc(0, OP_SW, 1, 1);  chk("lw_wb", 32'(strb), 32'(RGW | PCW | M2R));

        // SW whose ready lands on the limit cycle: no trap, retires
        cyc(0, OP_SW, 1, 1);  chk("sw1_fetch", 32'(strb), 32'(IMEM | IRW));
        chk("lw_retired", retired, 32'd2);
        cyc(0, OP_SW, 1, 0);  chk("sw1_decode", 32'(strb), 32'(NONE));
        cyc(0, OP_SW, 1, 0);  chk("sw1_exec", 32'(strb), 32'(ASRC));
        for (int i = 0; i < 14; i++) begin
            cyc(0, OP_SW, 1, 0); chk("sw1_mem_wait", 32'(strb), 32'(MWR));
        end
        cyc(0, OP_SW, 1, 1);  chk("sw1_ready_at_limit", 32'(strb), 32'(MWR | PCW));

        // SW with data memory stuck: trap after 15 MEM cycles
        cyc(0, OP_SW, 1, 1);  chk("sw2_fetch", 32'(strb), 32'(IMEM | IRW));
        chk("sw1_retired", retired, 32'd3);
        cyc(0, OP_SW, 1, 0);  chk("sw2_decode", 32'(strb), 32'(NONE));
        cyc(0, OP_SW, 1, 0);  chk("sw2_exec", 32'(strb), 32'(ASRC));
        for (int i = 0; i < 15; i++) begin
            cyc(0, OP_SW, 1, 0); chk("sw2_mem_wait", 32'(strb), 32'(MWR));
        end
        cyc(0, OP_SW, 1, 0);  chk("dmem_to_trap", 32'(strb), 32'(TRP));
        chk("dmem_to_cause", 32'(trap_cause), 32'd3);
        chk("dmem_to_retired", retired, 32'd3);
        cyc(0, OP_SW, 1, 1);  chk("trap_sticky", 32'(strb), 32'(TRP));

        // Reset out of TRAP, then an illegal opcode
        cyc(1, 7'd0, 1, 1);   chk("rst_trap_strobes", 32'(strb), 32'(NONE));
        chk("rst_trap_cause", 32'(trap_cause), 32'd0);
        chk("rst_trap_retired", retired, 32'd0);
        cyc(0, 7'd0, 1, 1);   chk("ill_fetch", 32'(strb), 32'(IMEM | IRW));
        cyc(0, 7'd0, 1, 1);   chk("ill_decode", 32'(strb), 32'(NONE));
        cyc(0, 7'd0, 1, 1);   chk("ill_trap", 32'(strb), 32'(TRP));
        chk("ill_cause", 32'(trap_cause), 32'd1);
        cyc(0, 7'd0, 1, 1);   chk("ill_sticky", 32'(strb), 32'(TRP));

        // JAL then HALT
        cyc(1, OP_JAL, 1, 1);
        cyc(0, OP_JAL, 1, 1);  chk("jal_fetch", 32'(strb), 32'(IMEM | IRW));
        cyc(0, OP_JAL, 1, 1);  chk("jal_decode", 32'(strb), 32'(NONE));
        cyc(0, OP_JAL, 1, 1);  chk("jal_exec", 32'(strb), 32'(JALP | RWS | RGW | PCW));
        cyc(0, OP_HALT, 1, 1); chk("halt_fetch", 32'(strb), 32'(IMEM | IRW));
        chk("jal_retired", retired, 32'd1);
        cyc(0, OP_HALT, 1, 1); chk("halt_decode", 32'(strb), 32'(NONE));
        cyc(0, OP_HALT, 1, 1); chk("halted", 32'(strb), 32'(HLT));
        chk("halted_cause", 32'(trap_cause), 32'd0);
        cyc(0, OP_HALT, 1, 1); chk("halted_sticky", 32'(strb), 32'(HLT));
        chk("halted_retired", retired, 32'd1);

        // Reset clears Halt; BR, JALR, I-type
        cyc(1, OP_BR, 1, 1);   chk("rst_halt_strobes", 32'(strb), 32'(NONE));
        cyc(0, OP_BR, 1, 1);   chk("br_fetch", 32'(strb), 32'(IMEM | IRW));
        cyc(0, OP_BR, 1, 1);   chk("br_decode", 32'(strb), 32'(NONE));
        cyc(0, OP_JALR, 1, 1); chk("br_exec", 32'(strb), 32'(BRN | PCW | AOP_BR));
        cyc(0, OP_JALR, 1, 1); chk("jalr_fetch", 32'(strb), 32'(IMEM | IRW));
        cyc(0, OP_JALR, 1, 1); chk("jalr_decode", 32'(strb), 32'(NONE));
        cyc(0, OP_ITY, 1, 1);  chk("jalr_exec", 32'(strb), 32'(JRS | RWS | RGW | ASRC | PCW));
        cyc(0, OP_ITY, 1, 1);  chk("ity_fetch", 32'(strb), 32'(IMEM | IRW));
        chk("br_jalr_retired", retired, 32'd2);
        cyc(0, OP_ITY, 1, 1);  chk("ity_decode", 32'(strb), 32'(NONE));
        cyc(0, OP_ITY, 1, 1);  chk("ity_exec", 32'(strb), 32'(ASRC | AOP_RI));
        cyc(0, OP_ITY, 0, 1);  chk("ity_wb", 32'(strb), 32'(RGW | PCW));

        // Instruction memory stuck: trap after 15 FETCH cycles
        for (int i = 0; i < 15; i++) begin
            cyc(0, OP_ITY, 0, 1); chk("imem_wait", 32'(strb), 32'(IMEM));
        end
        cyc(0, OP_ITY, 0, 1);  chk("imem_to_trap", 32'(strb), 32'(TRP));
        chk("imem_to_cause", 32'(trap_cause), 32'd2);
        chk("imem_to_retired", retired, 32'd3);

        // Reset asserted during SW in MEM
        cyc(1, OP_SW, 1, 1);
        cyc(0, OP_SW, 1, 1);   chk("sw3_fetch", 32'(strb), 32'(IMEM | IRW));
        cyc(0, OP_SW, 1, 0);   chk("sw3_decode", 32'(strb), 32'(NONE));
        cyc(0, OP_SW, 1, 0);   chk("sw3_exec", 32'(strb), 32'(ASRC));
        cyc(0, OP_SW, 1, 0);   chk("sw3_mem", 32'(strb), 32'(MWR));
        cyc(1, OP_SW, 1, 1);   chk("sw3_reset_in_mem", 32'(strb), 32'(NONE));
        cyc(1, OP_SW, 1, 1);   chk("sw3_after_reset", 32'(strb), 32'(NONE));
        chk("sw3_after_reset_retired", retired, 32'd0);
        cyc(0, OP_SW, 1, 1);   chk("sw3_restart_fetch", 32'(strb), 32'(IMEM | IRW));
        chk("sw3_restart_retired", retired, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
